// File: rtl/nn_layer_scheduler.sv
// Layer sequencer for the 784-20-20-10 MNIST datapath: steps ACC/ACT phases and strobes the result latch.
// Define NN_OUT_SIGMOID_EN to compile in the output-layer sigmoid phase (ACT3).
module nn_layer_scheduler #(
  parameter int N_IN   = 784,
  parameter int N_H1   = 20,
  parameter int N_H2   = 20,
  parameter int N_OUT  = 10,
  parameter int LAT    = 2,
  parameter int TICK_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Compute,
  input  logic              Abort,
  output logic [2:0]        Layer,
  output logic [TICK_W-1:0] Tick,
  output logic [2:0]        Active,
  output logic              AccClr,
  output logic              ActFuncActive,
  output logic              R,
  output logic              Ready,
  output logic              Busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC1 = 3'd1,
    S_ACT1 = 3'd2,
    S_ACC2 = 3'd3,
    S_ACT2 = 3'd4,
    S_ACC3 = 3'd5,
`ifdef NN_OUT_SIGMOID_EN
    S_ACT3 = 3'd7,
`endif
    S_DONE = 3'd6
  } state_t;

  localparam logic [TICK_W-1:0] LAT_T      = TICK_W'(LAT);
  localparam logic [TICK_W-1:0] ACC1_LAST  = TICK_W'(N_IN + LAT);
  localparam logic [TICK_W-1:0] ACT1_LAST  = TICK_W'(N_H1 + LAT - 1);
  localparam logic [TICK_W-1:0] ACC2_LAST  = TICK_W'(N_H1 + LAT);
  localparam logic [TICK_W-1:0] ACT2_LAST  = TICK_W'(N_H2 + LAT - 1);
  localparam logic [TICK_W-1:0] ACC3_LAST  = TICK_W'(N_H2 + LAT);
`ifdef NN_OUT_SIGMOID_EN
  localparam logic [TICK_W-1:0] ACT3_LAST  = TICK_W'(N_OUT + LAT - 1);
`endif

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TICK_W-1:0] last_tick;
  logic              phase_end;
  logic              is_acc, is_act;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  // Phase exit is by compare against the last tick; the counter never wraps.
  always_comb begin
    last_tick = '0;
    case (state_q)
      S_ACC1:  last_tick = ACC1_LAST;
      S_ACT1:  last_tick = ACT1_LAST;
      S_ACC2:  last_tick = ACC2_LAST;
      S_ACT2:  last_tick = ACT2_LAST;
      S_ACC3:  last_tick = ACC3_LAST;
`ifdef NN_OUT_SIGMOID_EN
      S_ACT3:  last_tick = ACT3_LAST;
`endif
      default: last_tick = '0;
    endcase
    phase_end = (tick_q == last_tick);

    state_d = state_q;
    tick_d  = tick_q + TICK_W'(1);
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (Compute) state_d = S_ACC1;
      end
      S_ACC1: if (phase_end) state_d = S_ACT1;
      S_ACT1: if (phase_end) state_d = S_ACC2;
      S_ACC2: if (phase_end) state_d = S_ACT2;
      S_ACT2: if (phase_end) state_d = S_ACC3;
`ifdef NN_OUT_SIGMOID_EN
      S_ACC3: if (phase_end) state_d = S_ACT3;
      S_ACT3: if (phase_end) state_d = S_DONE;
`else
      S_ACC3: if (phase_end) state_d = S_DONE;
`endif
      S_DONE: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
    if (phase_end && state_q != S_IDLE && state_q != S_DONE) tick_d = '0;
    if (Abort) begin
      state_d = S_IDLE;
      tick_d  = '0;
    end
  end

  always_comb begin
    Layer  = 3'b000;
    is_acc = 1'b0;
    is_act = 1'b0;
    case (state_q)
      S_ACC1: begin Layer = 3'b001; is_acc = 1'b1; end
      S_ACT1: begin Layer = 3'b001; is_act = 1'b1; end
      S_ACC2: begin Layer = 3'b010; is_acc = 1'b1; end
      S_ACT2: begin Layer = 3'b010; is_act = 1'b1; end
      S_ACC3: begin Layer = 3'b100; is_acc = 1'b1; end
`ifdef NN_OUT_SIGMOID_EN
      S_ACT3: begin Layer = 3'b100; is_act = 1'b1; end
`endif
      default: ;
    endcase
    Tick          = tick_q;
    Active        = (is_acc && tick_q >= LAT_T) ? Layer : 3'b000;
    AccClr        = is_acc && (tick_q == '0);
    ActFuncActive = is_act && (tick_q >= LAT_T);
    R             = (state_q == S_DONE);
    Ready         = (state_q == S_IDLE);
    Busy          = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_nn_layer_scheduler.sv
// Directed bench for nn_layer_scheduler: scoreboard of expected R cycles plus phase-strobe counters.
module tb_nn_layer_scheduler;
  localparam int TW = 10;
`ifdef NN_OUT_SIGMOID_EN
  localparam int RUN = 890;
  localparam int AFA = 50;
  localparam int AFA3 = 10;
`else
  localparam int RUN = 878;
  localparam int AFA = 40;
  localparam int AFA3 = 0;
`endif

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Compute = 1'b0;
  logic          Abort = 1'b0;
  logic [2:0]    Layer, Active;
  logic [TW-1:0] Tick;
  logic          AccClr, ActFuncActive, R, Ready, Busy;

  nn_layer_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .Compute(Compute), .Abort(Abort),
    .Layer(Layer), .Tick(Tick), .Active(Active), .AccClr(AccClr),
    .ActFuncActive(ActFuncActive), .R(R), .Ready(Ready), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int act0 = 0, act1 = 0, act2 = 0, clr_cnt = 0, afa_cnt = 0, afa3_cnt = 0, afa3_last = -1;
  int obs[$];
  int sb[$];

  always @(negedge Clk) begin
    if (Active[0]) act0++;
    if (Active[1]) act1++;
    if (Active[2]) act2++;
    if (AccClr) clr_cnt++;
    if (ActFuncActive) afa_cnt++;
    if (ActFuncActive && Layer == 3'b100) begin
      afa3_cnt++;
      afa3_last = int'(Tick);
    end
    if (R) obs.push_back(cyc);
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic wait_r(input int bound);
    int n = 0;
    int o, e;
    while (obs.size() == 0 && n < bound) begin
      step(1);
      n++;
    end
    if (obs.size() == 0) chk("r_timeout", 32'd0, 32'd1);
    else begin
      o = obs.pop_front();
      e = (sb.size() != 0) ? sb.pop_front() : -1;
      chk("r_cycle", o, e);
    end
  endtask

  initial begin
    int c0, c1;
    int s0, s1, s2, sc, sa, s3;

    // reset held with Compute asserted
    Reset_n = 1'b0;
    Compute = 1'b1;
    step(3);
    chk("rst_layer", Layer, 3'b000);
    chk("rst_tick", Tick, 0);
    chk("rst_active", Active, 3'b000);
    chk("rst_accclr", AccClr, 0);
    chk("rst_afa", ActFuncActive, 0);
    chk("rst_r", R, 0);
    chk("rst_ready", Ready, 1);
    chk("rst_busy", Busy, 0);
    Compute = 1'b0;
    Reset_n = 1'b1;
    step(2);
    chk("idle_ready", Ready, 1);

    // full run
    s0 = act0; s1 = act1; s2 = act2; sc = clr_cnt; sa = afa_cnt; s3 = afa3_cnt;
    c0 = cyc;
    Compute = 1'b1;
    sb.push_back(c0 + RUN);
    step(1);
    Compute = 1'b0;
    chk("acc1_layer", Layer, 3'b001);
    chk("acc1_tick0", Tick, 0);
    chk("acc1_clr", AccClr, 1);
    chk("acc1_active_t0", Active, 3'b000);
    chk("acc1_busy", Busy, 1);
    chk("acc1_ready", Ready, 0);
    step(2);
    chk("acc1_tick2", Tick, 2);
    chk("acc1_active_t2", Active, 3'b001);
    wait_r(RUN + 20);
    chk("post_r_ready", Ready, 1);
    chk("post_r_busy", Busy, 0);
    chk("post_r_layer", Layer, 3'b000);
    chk("act0_cycles", act0 - s0, 785);
    chk("act1_cycles", act1 - s1, 21);
    chk("act2_cycles", act2 - s2, 21);
    chk("accclr_pulses", clr_cnt - sc, 3);
    chk("afa_cycles", afa_cnt - sa, AFA);
    chk("afa_layer3_cycles", afa3_cnt - s3, AFA3);
`ifdef NN_OUT_SIGMOID_EN
    chk("afa_layer3_last_tick", afa3_last, 11);
`endif
    step(3);
    chk("no_extra_r", obs.size(), 0);

    // Compute during ACC2 is ignored
    c0 = cyc;
    Compute = 1'b1;
    sb.push_back(c0 + RUN);
    step(1);
    Compute = 1'b0;
    wait_until(c0 + 1 + 787 + 22 + 5);
    chk("acc2_layer", Layer, 3'b010);
    chk("acc2_active", Active, 3'b010);
    Compute = 1'b1;
    step(1);
    Compute = 1'b0;
    wait_r(RUN + 20);
    step(5);
    chk("acc2_compute_ignored", obs.size(), 0);

    // Compute held high: back-to-back runs
    c0 = cyc;
    Compute = 1'b1;
    sb.push_back(c0 + RUN);
    sb.push_back(c0 + 2 * RUN + 1);
    wait_until(c0 + RUN + 1);
    chk("b2b_idle_gap", Ready, 1);
    step(1);
    chk("b2b_restart_layer", Layer, 3'b001);
    chk("b2b_restart_clr", AccClr, 1);
    wait_r(20);
    wait_until(c0 + 2 * RUN + 1);
    chk("b2b_second_r", R, 1);
    Compute = 1'b0;
    wait_r(20);
    chk("b2b_ready", Ready, 1);
    step(3);
    chk("b2b_no_third", Busy, 0);

    // Abort at ACC1 Tick=400
    c0 = cyc;
    Compute = 1'b1;
    step(1);
    Compute = 1'b0;
    wait_until(c0 + 401);
    chk("abort_tick400", Tick, 400);
    Abort = 1'b1;
    step(1);
    Abort = 1'b0;
    chk("abort_ready", Ready, 1);
    chk("abort_tick", Tick, 0);
    chk("abort_layer", Layer, 3'b000);
    step(RUN + 10);
    chk("abort_no_r", obs.size(), 0);
    Abort = 1'b1;
    Compute = 1'b1;
    step(3);
    chk("abort_compute_ready", Ready, 1);
    chk("abort_compute_busy", Busy, 0);
    Abort = 1'b0;
    Compute = 1'b0;
    step(1);

    // one-cycle reset during ACT2
    c0 = cyc;
    Compute = 1'b1;
    step(1);
    Compute = 1'b0;
    wait_until(c0 + 840);
    chk("act2_layer", Layer, 3'b010);
    chk("act2_afa", ActFuncActive, 1);
    Reset_n = 1'b0;
    step(1);
    Reset_n = 1'b1;
    chk("midrst_ready", Ready, 1);
    chk("midrst_tick", Tick, 0);
    chk("midrst_layer", Layer, 3'b000);
    chk("midrst_afa", ActFuncActive, 0);
    c1 = cyc;
    Compute = 1'b1;
    sb.push_back(c1 + RUN);
    step(1);
    Compute = 1'b0;
    wait_r(RUN + 20);
    step(3);
    chk("midrst_single_r", obs.size(), 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nn_layer_scheduler.md
# nn_layer_scheduler

Sequencer for the three-layer MNIST inference datapath (784→20→20→10). On a start request it steps the shared weight/input BRAM addresses, neuron accumulate enables and sigmoid-ROM writeback through each layer in turn. At completion it pulses a result-latch strobe. It sits between the host handshake and the `neural_network` datapath. It drives the layer select, tick counter and phase strobes that the datapath's address/mux logic decodes.

## Interface
- `N_IN`, 784, fan-in of layer 1
- `N_H1`, 20, neurons in layer 1 (fan-in of layer 2)
- `N_H2`, 20, neurons in layer 2 (fan-in of layer 3)
- `N_OUT`, 10, neurons in output layer
- `LAT`, 2, BRAM/ROM read latency in cycles
- `TICK_W`, 10, tick counter width; must hold `N_IN+LAT`

- `Clk` in 1 — single clock, rising edge
- `Reset_n` in 1 — synchronous, active-low reset
- `Compute` in 1 — start request, sampled in IDLE only
- `Abort` in 1 — cancel run, any state
- `Layer` out 3 — one-hot layer select (001/010/100); 000 in IDLE/DONE
- `Tick` out TICK_W — phase-local counter, drives BRAM/ROM address offsets
- `Active` out 3 — one-hot neuron accumulate enable for the current layer
- `AccClr` out 1 — one-cycle clear of the current layer's accumulators
- `ActFuncActive` out 1 — sigmoid writeback enable
- `R` out 1 — one-cycle result-latch strobe
- `Ready` out 1 — high in IDLE
- `Busy` out 1 — high from first ACC1 cycle through DONE

## Operation
- States: IDLE, ACC1, ACT1, ACC2, ACT2, ACC3, ACT3 (only with macro), DONE.
- IDLE: `Compute`=1 → ACC1, `Tick`←0.
- ACCn with fan-in F:
  - `Tick` counts 0..F+LAT.
  - `AccClr`=1 at `Tick`=0.
  - `Active[n-1]`=1 for LAT ≤ `Tick` ≤ F+LAT: F weight·input products followed by 1 bias term. The datapath supplies bias input 1<<11 when `Tick`−LAT = F.
  - At `Tick`=F+LAT → ACTn (or DONE for ACC3 without macro), `Tick`←0.
- ACTn with N neurons:
  - `Tick` counts 0..N+LAT−1 and addresses sigmoid ROM with z[`Tick`].
  - `ActFuncActive`=1 for LAT ≤ `Tick` ≤ N+LAT−1; writeback index is `Tick`−LAT.
  - At the last tick → next ACC, or DONE after the final layer.
- DONE: `R`=1 for one cycle, then IDLE unconditionally. `Compute` in DONE is ignored.
- `Compute` while not in IDLE is ignored; it is not queued.
- `Abort`=1 → IDLE next edge from any state. No `R` is issued and datapath contents are not cleared. `Abort` and `Compute` together in IDLE: `Abort` wins, stay IDLE.
- `Tick` never wraps; phase exit is by compare, not overflow.

## Timing
- Reset (`Reset_n`=0 at an edge):
  - State IDLE, `Tick`=0, `Layer`=000, `Active`=000.
  - `AccClr`=0, `ActFuncActive`=0, `R`=0.
  - `Ready`=1, `Busy`=0.
  - Reset mid-run aborts identically to `Abort`.
- All outputs are registered or pure decodes of state+`Tick`; no combinational path from inputs to outputs.
- Phase lengths with defaults: ACC1 787, ACT1 22, ACC2 23, ACT2 22, ACC3 23, ACT3 12 cycles.
- `Compute` high in cycle 0 → ACC1 in cycle 1. `R` in cycle 878 without macro, 890 with it. `Ready` is back high in the cycle after `R`.
- Back-to-back runs: `Compute` may be held high; the next run starts on the first IDLE cycle.

## Configuration
- `NN_OUT_SIGMOID_EN`
  - Defined: ACT3 is compiled in. Output-layer sigmoid is written back before DONE. Latency +N_OUT+LAT cycles.
  - Undefined: ACC3 → DONE directly. `R` latches raw z_3 outputs, `ActFuncActive` never asserts in layer 3, and the ACT3 state encoding is absent.

## Test plan
- Reset: hold `Reset_n`=0 while `Compute`=1 → all outputs at reset values, `Ready`=1.
- Full run, macro off: `Compute` pulse at cycle 0 → `R` single-cycle pulse at 878.
  - `Active[0]` high for exactly 785 cycles, `Active[1]` 21, `Active[2]` 21.
  - `AccClr` 3 pulses, `ActFuncActive` high 40 cycles total.
- Full run, macro on: same stimulus → `R` at 890, `ActFuncActive` high 50 cycles; last layer-3 writeback at `Tick`=11.
- `Compute` re-asserted during ACC2 → no effect, `R` timing unchanged. `Compute` held high continuously → consecutive runs with exactly one IDLE cycle between `R` and the next ACC1.
- `Abort` at ACC1 `Tick`=400 → IDLE next cycle, no `R`. `Abort`+`Compute` together in IDLE → stays IDLE.
- `Reset_n`=0 for one cycle during ACT2 → IDLE with reset outputs; a new `Compute` then yields `R` exactly 878 cycles later.
